// File: rtl/tile_pkg.sv
// Shared FSM state types and default tile geometry for the tile write-back path.
package tile_pkg;

    typedef enum logic {RIdle, RRead} rd_state_e;
    typedef enum logic {WIdle, WBurst} wr_state_e;

    localparam int unsigned DefTileW     = 16;
    localparam int unsigned DefTileH     = 32;
    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefFifoDepth = 64;
    localparam int unsigned DefRamLat    = 2;

endpackage

// File: rtl/tile_burst_writer_fifo.sv
// Show-ahead single-clock FIFO with an occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    used_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            used_q <= used_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign used  = used_q;

endmodule

// File: rtl/tile_burst_writer.sv
// Streams one tile from tile RAM (or a clear colour) through a FIFO and writes it to the
// framebuffer as one Avalon-MM burst per tile row.
module tile_burst_writer
    import tile_pkg::*;
#(
    parameter int unsigned TILE_W     = DefTileW,
    parameter int unsigned TILE_H     = DefTileH,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned RAM_LAT    = DefRamLat
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      addr_in,
    input  logic [15:0]                      stride_in,
    input  logic                             clear_mode,
    input  logic [DATA_W-1:0]                clear_value,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             ram_rd,
    output logic [$clog2(TILE_W*TILE_H)-1:0] ram_addr_out,
    input  logic [DATA_W-1:0]                ram_data,
    output logic [31:0]                      master_address,
    output logic                             master_write,
    output logic [DATA_W-1:0]                master_writedata,
    output logic [$clog2(TILE_W):0]          master_burstcount,
    output logic [DATA_W/8-1:0]              master_byteenable,
    input  logic                             master_waitrequest
);

    localparam int unsigned NumPix = TILE_W * TILE_H;
    localparam int unsigned RamAw  = $clog2(NumPix);
    localparam int unsigned BcW    = $clog2(TILE_W) + 1;
    localparam int unsigned RowW   = $clog2(TILE_H) + 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SumW   = CntW + 1;

    rd_state_e         rd_state_q, rd_state_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic              busy_q, done_q, clr_mode_q;
    logic [DATA_W-1:0] clr_val_q, push_data, fifo_head;
    logic [31:0]       row_addr_q, master_address_q, next_row_addr;
    logic [15:0]       stride_q;
    logic [RamAw-1:0]  ram_addr_q;
    logic [RAM_LAT-1:0] vld_q;
    logic [CntW-1:0]   in_flight_q, fifo_used, used_next;
    logic [SumW-1:0]   credit_sum;
    logic [BcW-1:0]    beat_q;
    logic [RowW-1:0]   row_q;
    logic              accept, issue, last_addr, push, pop, last_beat, last_row, load_addr;

    assign accept        = start && !busy_q;
    assign last_addr     = (ram_addr_q == RamAw'(NumPix - 1));
    assign last_row      = (row_q == RowW'(TILE_H - 1));
    assign next_row_addr = row_addr_q + {16'h0000, stride_q};
    // Reads still in the RAM pipeline hold FIFO credit so a push can never overflow.
    assign credit_sum    = SumW'(fifo_used) + SumW'(in_flight_q);

    always_comb begin
        rd_state_d = rd_state_q;
        wr_state_d = wr_state_q;
        load_addr  = 1'b0;
        issue      = (rd_state_q == RRead) && (credit_sum < SumW'(FIFO_DEPTH));
        push       = (issue && clr_mode_q) || vld_q[RAM_LAT-1];
        push_data  = clr_mode_q ? clr_val_q : ram_data;
        pop        = (wr_state_q == WBurst) && !master_waitrequest;
        last_beat  = pop && (beat_q == BcW'(TILE_W - 1));
        used_next  = fifo_used + CntW'(push) - CntW'(pop);

        unique case (rd_state_q)
            RIdle:   if (accept) rd_state_d = RRead;
            RRead:   if (issue && last_addr) rd_state_d = RIdle;
            default: rd_state_d = RIdle;
        endcase

        unique case (wr_state_q)
            WIdle: begin
                if (busy_q && fifo_used >= CntW'(TILE_W)) begin
                    wr_state_d = WBurst;
                    load_addr  = 1'b1;
                end
            end
            WBurst: begin
                if (last_beat) begin
                    if (!last_row && used_next >= CntW'(TILE_W)) load_addr = 1'b1;
                    else                                          wr_state_d = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q       <= RIdle;
            wr_state_q       <= WIdle;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            clr_mode_q       <= 1'b0;
            clr_val_q        <= '0;
            row_addr_q       <= '0;
            stride_q         <= '0;
            master_address_q <= '0;
            ram_addr_q       <= '0;
            vld_q            <= '0;
            in_flight_q      <= '0;
            beat_q           <= '0;
            row_q            <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            done_q      <= last_beat && last_row;
            vld_q       <= RAM_LAT'({vld_q, ram_rd});
            in_flight_q <= in_flight_q + CntW'(ram_rd) - CntW'(vld_q[RAM_LAT-1]);
            if (accept) begin
                busy_q     <= 1'b1;
                row_addr_q <= addr_in;
                stride_q   <= stride_in;
                clr_mode_q <= clear_mode;
                clr_val_q  <= clear_value;
            end
            if (issue) ram_addr_q <= last_addr ? '0 : ram_addr_q + RamAw'(1);
            // Entering from idle uses the current row; chaining uses the row just advanced to.
            if (load_addr) begin
                master_address_q <= (wr_state_q == WIdle) ? row_addr_q : next_row_addr;
            end
            if (last_beat) begin
                beat_q     <= '0;
                row_addr_q <= next_row_addr;
                row_q      <= last_row ? '0 : row_q + RowW'(1);
                if (last_row) busy_q <= 1'b0;
            end else if (pop) begin
                beat_q <= beat_q + BcW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_head),
        .used  (fifo_used)
    );

    assign busy              = busy_q;
    assign done              = done_q;
    assign ram_rd            = issue && !clr_mode_q;
    assign ram_addr_out      = ram_addr_q;
    assign master_address    = master_address_q;
    assign master_write      = (wr_state_q == WBurst);
    assign master_writedata  = fifo_head;
    assign master_burstcount = BcW'(TILE_W);
    assign master_byteenable = '1;

endmodule

// File: tb/tb_tile_burst_writer.sv
// Bench for tile_burst_writer: a table of tile jobs checked beat by beat against a reference
// model, plus mid-burst reset and a small-geometry instance.
module tb_tile_burst_writer;

    localparam int TW  = 16;
    localparam int TH  = 32;
    localparam int NP  = TW * TH;
    localparam int STW = 8;
    localparam int STH = 8;
    localparam int SNP = STW * STH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear_mode, busy, done, ram_rd, master_write, master_waitrequest;
    logic [31:0] addr_in, clear_value, ram_data, master_address, master_writedata;
    logic [15:0] stride_in;
    logic [8:0]  ram_addr_out;
    logic [4:0]  master_burstcount;
    logic [3:0]  master_byteenable;

    logic        s_rst, s_start, s_clear_mode, s_busy, s_done, s_ram_rd, s_master_write;
    logic        s_master_waitrequest;
    logic [31:0] s_addr_in, s_clear_value, s_ram_data, s_master_address, s_master_writedata;
    logic [15:0] s_stride_in;
    logic [5:0]  s_ram_addr_out;
    logic [3:0]  s_master_burstcount;
    logic [3:0]  s_master_byteenable;

    tile_burst_writer dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .stride_in(stride_in),
        .clear_mode(clear_mode), .clear_value(clear_value), .start(start), .busy(busy),
        .done(done), .ram_rd(ram_rd), .ram_addr_out(ram_addr_out), .ram_data(ram_data),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_burstcount(master_burstcount),
        .master_byteenable(master_byteenable), .master_waitrequest(master_waitrequest)
    );

    tile_burst_writer #(
        .TILE_W(STW), .TILE_H(STH), .DATA_W(32), .FIFO_DEPTH(8), .RAM_LAT(1)
    ) dut_s (
        .clk(clk), .rst(s_rst), .addr_in(s_addr_in), .stride_in(s_stride_in),
        .clear_mode(s_clear_mode), .clear_value(s_clear_value), .start(s_start),
        .busy(s_busy), .done(s_done), .ram_rd(s_ram_rd), .ram_addr_out(s_ram_addr_out),
        .ram_data(s_ram_data), .master_address(s_master_address),
        .master_write(s_master_write), .master_writedata(s_master_writedata),
        .master_burstcount(s_master_burstcount), .master_byteenable(s_master_byteenable),
        .master_waitrequest(s_master_waitrequest)
    );

    // Tile RAM models: latency 2 for the default instance, 1 for the small one.
    logic [31:0] mem [NP];
    logic [31:0] s_mem [SNP];
    logic [31:0] rp0, rp1, s_rp;
    always @(posedge clk) begin
        rp0  <= ram_rd ? mem[ram_addr_out] : 32'hBAD0BAD0;
        rp1  <= rp0;
        s_rp <= s_ram_rd ? s_mem[s_ram_addr_out] : 32'hBAD0BAD0;
    end
    assign ram_data   = rp1;
    assign s_ram_data = s_rp;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] stride;
        logic        clr;
        logic [31:0] cval;
        bit          bp;
        bit          dbl;
        logic [31:0] exp_row0;
        logic [31:0] exp_row1;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    int  checks = 0;
    int  errors = 0;
    bit  bp_en = 1'b0;
    bit  s_bp_en = 1'b0;

    logic [31:0] m_addr, m_cval;
    logic [15:0] m_stride;
    logic        m_clr;
    int          mon_beat, mon_bcnt, done_cnt, rd_cnt, max_used;
    bit          exp_done, tile_done, in_burst;
    logic [31:0] burst_addr;
    logic [31:0] row_seen [TH];

    logic [31:0] s_m_addr;
    logic [15:0] s_m_stride;
    int          s_beat, s_done_cnt;
    bit          s_exp_done, s_tile_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_beat = 0; mon_bcnt = 0; done_cnt = 0; rd_cnt = 0; max_used = 0;
        exp_done = 1'b0; tile_done = 1'b0; in_burst = 1'b0;
        for (int r = 0; r < TH; r++) row_seen[r] = 32'h0000_0001;
    endtask

    // One cycle: drive waitrequest for the coming edge, then observe what that edge will do.
    task automatic step();
        logic [31:0] ea;
        @(negedge clk);
        master_waitrequest   = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
        s_master_waitrequest = s_bp_en ? 1'($urandom_range(0, 1)) : 1'b0;

        if (exp_done) begin
            chk("done_pulse", 64'(done), 64'd1);
            chk("busy_fall", 64'(busy), 64'd0);
            exp_done  = 1'b0;
            tile_done = 1'b1;
        end else if (done) begin
            done_cnt++;
        end
        if (ram_rd) rd_cnt++;
        if (int'(dut.fifo_used) > max_used) max_used = int'(dut.fifo_used);
        if (master_write) begin
            chk("burstcount", 64'(master_burstcount), 64'(TW));
            if (!in_burst) begin
                burst_addr = master_address;
                in_burst   = 1'b1;
            end else begin
                chk("addr_stable", 64'(master_address), 64'(burst_addr));
            end
            if (!master_waitrequest) begin
                if (mon_beat >= NP) begin
                    chk("extra_beat", 64'(mon_beat), 64'(NP - 1));
                end else begin
                    ea = m_addr + 32'(mon_beat / TW) * {16'h0000, m_stride};
                    chk("beat_addr", 64'(master_address), 64'(ea));
                    chk("beat_data", 64'(master_writedata),
                        64'(m_clr ? m_cval : mem[mon_beat]));
                    if (mon_beat % TW == 0) row_seen[mon_beat / TW] = master_address;
                    mon_beat++;
                    mon_bcnt++;
                    if (mon_bcnt == TW) begin
                        mon_bcnt = 0;
                        in_burst = 1'b0;
                    end
                    if (mon_beat == NP) exp_done = 1'b1;
                end
            end
        end

        if (s_exp_done) begin
            chk("s_done_pulse", 64'(s_done), 64'd1);
            chk("s_busy_fall", 64'(s_busy), 64'd0);
            s_exp_done  = 1'b0;
            s_tile_done = 1'b1;
        end else if (s_done) begin
            s_done_cnt++;
        end
        if (s_master_write) begin
            chk("s_burstcount", 64'(s_master_burstcount), 64'(STW));
            if (!s_master_waitrequest) begin
                if (s_beat >= SNP) begin
                    chk("s_extra_beat", 64'(s_beat), 64'(SNP - 1));
                end else begin
                    ea = s_m_addr + 32'(s_beat / STW) * {16'h0000, s_m_stride};
                    chk("s_beat_addr", 64'(s_master_address), 64'(ea));
                    chk("s_beat_data", 64'(s_master_writedata), 64'(s_mem[s_beat]));
                    s_beat++;
                    if (s_beat == SNP) s_exp_done = 1'b1;
                end
            end
        end
    endtask

    task automatic run_tile(input logic [31:0] a, input logic [15:0] s, input logic clr,
                            input logic [31:0] cv, input bit bp, input bit dbl);
        int n;
        m_addr = a; m_stride = s; m_clr = clr; m_cval = cv;
        clear_mon();
        bp_en = bp;
        addr_in = a; stride_in = s; clear_mode = clr; clear_value = cv; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
        n = 0;
        while (!tile_done && n < 20000) begin
            step();
            n++;
            if (dbl && n == 40) begin
                addr_in = 32'h5555_0000; stride_in = 16'h0004; clear_mode = ~clr;
                clear_value = 32'h0BAD_F00D; start = 1'b1;
            end else if (dbl && n == 41) begin
                start = 1'b0;
            end
        end
        bp_en = 1'b0;
        if (!tile_done) begin
            checks++;
            errors++;
            $display("FAIL tile_timeout: got %0d beats, expected %0d", mon_beat, NP);
        end
        chk("beat_count", 64'(mon_beat), 64'(NP));
        chk("spurious_done", 64'(done_cnt), 64'd0);
        chk("ram_rd_count", 64'(rd_cnt), clr ? 64'd0 : 64'(NP));
        chk("fifo_max_le_depth", 64'(max_used <= 64), 64'd1);
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_no_write", 64'(master_write), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] ra;
        logic [15:0] rs;
        rst = 1'b1; start = 1'b0; clear_mode = 1'b0; addr_in = '0; stride_in = '0;
        clear_value = '0; master_waitrequest = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_clear_mode = 1'b0; s_addr_in = '0; s_stride_in = '0;
        s_clear_value = '0; s_master_waitrequest = 1'b0;
        for (int k = 0; k < NP; k++) mem[k] = 32'(k);
        for (int k = 0; k < SNP; k++) s_mem[k] = 32'hA000_0000 + 32'(k * 3);
        clear_mon();
        s_beat = 0; s_done_cnt = 0; s_exp_done = 1'b0; s_tile_done = 1'b0;
        s_m_addr = '0; s_m_stride = '0;
        repeat (3) step();

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ram_rd", 64'(ram_rd), 64'd0);
        chk("rst_master_write", 64'(master_write), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr_out), 64'd0);
        chk("rst_master_address", 64'(master_address), 64'd0);
        chk("byteenable", 64'(master_byteenable), 64'hF);
        chk("s_rst_busy", 64'(s_busy), 64'd0);
        chk("s_rst_master_write", 64'(s_master_write), 64'd0);
        chk("s_byteenable", 64'(s_master_byteenable), 64'hF);
        rst = 1'b0; s_rst = 1'b0;
        step();

        ra = $urandom & 32'hFFFF_FFFC;
        rs = 16'($urandom) & 16'hFFFC;
        vecs[0] = '{32'h0000_1000, 16'h0400, 1'b0, 32'h0, 1'b0, 1'b0,
                    32'h0000_1000, 32'h0000_1400, 32'h0000_8C00};
        vecs[1] = '{32'h0000_1000, 16'h0400, 1'b0, 32'h0, 1'b1, 1'b0,
                    32'h0000_1000, 32'h0000_1400, 32'h0000_8C00};
        vecs[2] = '{32'h0000_2000, 16'h0040, 1'b1, 32'hFF00_FF00, 1'b0, 1'b0,
                    32'h0000_2000, 32'h0000_2040, 32'h0000_27C0};
        vecs[3] = '{32'hFFFF_FC00, 16'h0400, 1'b0, 32'h0, 1'b0, 1'b1,
                    32'hFFFF_FC00, 32'h0000_0000, 32'h0000_7800};
        vecs[4] = '{ra, rs, 1'b0, 32'h0, 1'b1, 1'b0,
                    ra, ra + {16'h0, rs}, ra + 32'd31 * {16'h0, rs}};

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NP; k++) mem[k] = (i == 4) ? $urandom : 32'(k);
            run_tile(vecs[i].addr, vecs[i].stride, vecs[i].clr, vecs[i].cval,
                     vecs[i].bp, vecs[i].dbl);
            chk("row0_addr", 64'(row_seen[0]), 64'(vecs[i].exp_row0));
            chk("row1_addr", 64'(row_seen[1]), 64'(vecs[i].exp_row1));
            chk("last_row_addr", 64'(row_seen[TH-1]), 64'(vecs[i].exp_last));
        end

        // Reset while burst 5 beat 7 is on the bus, then a clean tile.
        for (int k = 0; k < NP; k++) mem[k] = 32'(k) ^ 32'h00C0_FFEE;
        m_addr = 32'h0000_3000; m_stride = 16'h0100; m_clr = 1'b0; m_cval = '0;
        clear_mon();
        addr_in = m_addr; stride_in = m_stride; clear_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (mon_beat < 5 * TW + 8 && n < 5000) begin
            step();
            n++;
        end
        chk("reached_burst5_beat7", 64'(mon_beat), 64'(5 * TW + 8));
        rst = 1'b1;
        step();
        chk("midrst_master_write", 64'(master_write), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ram_rd", 64'(ram_rd), 64'd0);
        rst = 1'b0;
        step();
        run_tile(32'h0000_3000, 16'h0100, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("after_rst_row0", 64'(row_seen[0]), 64'h3000);
        chk("after_rst_last", 64'(row_seen[TH-1]), 64'h3000 + 64'd31 * 64'h100);

        // Small geometry: 8x8 tile, RAM latency 1, 8-entry FIFO, random backpressure.
        s_m_addr = 32'h0000_0500; s_m_stride = 16'h0020;
        s_beat = 0; s_done_cnt = 0; s_exp_done = 1'b0; s_tile_done = 1'b0;
        s_bp_en = 1'b1;
        s_addr_in = s_m_addr; s_stride_in = s_m_stride; s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("s_busy_rise", 64'(s_busy), 64'd1);
        n = 0;
        while (!s_tile_done && n < 5000) begin
            step();
            n++;
        end
        s_bp_en = 1'b0;
        chk("s_tile_completed", 64'(s_tile_done), 64'd1);
        chk("s_beat_count", 64'(s_beat), 64'(SNP));
        chk("s_spurious_done", 64'(s_done_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_burst_writer.md
Name: tile_burst_writer

Overview:
- Single-clock, parametrised successor of the tile write-back path.
- Streams one TILE_W x TILE_H tile from tile RAM into an internal FIFO, then writes it to the framebuffer as one Avalon-MM burst per tile row.
- Adds a clear mode that writes a constant colour without reading tile RAM, plus a done pulse.
- Sits between the rasteriser's tile RAM and the memory interconnect.

Parameters:
- TILE_W, 16, pixels per tile row; also the burst length.
- TILE_H, 32, rows per tile.
- DATA_W, 32, pixel/bus data width in bits (byte multiple).
- FIFO_DEPTH, 64, internal FIFO entries; power of two, >= TILE_W.
- RAM_LAT, 2, tile RAM read latency in cycles (>= 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr_in  in  32  framebuffer byte address of tile pixel (0,0)
- stride_in  in  16  framebuffer row pitch in bytes
- clear_mode  in  1  sampled at start; 1 = write clear_value instead of RAM data
- clear_value  in  DATA_W  sampled at start
- start  in  1  begin a tile; ignored while busy
- busy  out  1  high from accepted start until the last beat is accepted
- done  out  1  one-cycle pulse, registered, in the cycle after the last beat is accepted
- ram_rd  out  1  tile RAM read strobe
- ram_addr_out  out  $clog2(TILE_W*TILE_H)  tile RAM word address, row-major
- ram_data  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_rd
- master_address  out  32
- master_write  out  1
- master_writedata  out  DATA_W
- master_burstcount  out  $clog2(TILE_W)+1
- master_byteenable  out  DATA_W/8  always all ones
- master_waitrequest  in  1

Behaviour:
Reset:
- busy, done, ram_rd, master_write = 0.
- ram_addr_out, master_address, FIFO pointers, counters = 0.
- Both FSMs go to idle.
- Reset mid-burst drops master_write in the next cycle; the truncated burst is accepted as a system-reset hazard.

Start:
- When !busy && start, latch addr_in, stride_in, clear_mode and clear_value.
- busy rises the next cycle.
- start while busy has no effect.

Reader FSM (R_IDLE, R_READ):
- Issues one ram_rd per cycle, ram_addr_out incrementing 0..TILE_W*TILE_H-1.
- A read issues only if fifo_used + in_flight < FIFO_DEPTH. in_flight counts reads not yet returned, so the FIFO never overflows.
- Returned data is pushed exactly RAM_LAT cycles after its ram_rd, tracked by a RAM_LAT-deep valid shift register.
- Returns to R_IDLE after the last address is issued.
- In clear mode, ram_rd stays 0 and clear_value is pushed directly under the same credit rule.

Writer FSM (W_IDLE, W_BURST):
- Leaves W_IDLE only when fifo_used >= TILE_W, so a burst never stalls on empty data.
- On entry: master_address = row_addr, master_burstcount = TILE_W, master_write = 1.
- Address and burstcount are held constant for the whole burst.
- master_writedata = FIFO head (show-ahead).
- Each cycle with master_write && !master_waitrequest pops one entry and counts a beat.
- After beat TILE_W-1:
  - row_addr += stride, mod 2^32, no saturation; row counter increments.
  - If another row is already buffered, the next burst starts in the following cycle; otherwise master_write = 0 in W_IDLE.
- After row TILE_H-1's final beat: busy = 0 and done = 1 in the next cycle. No FIFO entries remain.

Simultaneous push and pop in one cycle: fifo_used is unchanged.

Throughput: one beat per cycle with no backpressure. Total tile latency is about RAM_LAT + TILE_W + TILE_W*TILE_H cycles.

Decomposition:
- Package tile_pkg holds the reader and writer state enums and default tile-geometry constants. The localparams (RAM address width, burstcount width) are derived in the module.
- One sub-module, sync_fifo #(WIDTH, DEPTH): show-ahead, single clock, with used-count output.

Test Plan:
- Basic tile: 16x32, addr 0x1000, stride 0x400, RAM word i = i, no waitrequest -> 32 bursts of 16 at 0x1000, 0x1400, ..., 0x8C00. Data 0..511 in order; done one cycle after beat 512; busy low the same cycle.
- Backpressure: same tile, random 50% master_waitrequest -> identical address/data sequence. Address and burstcount stable within each burst; FIFO never exceeds 64; no lost or duplicated beats.
- Clear mode: clear_value 0xFF00FF00, addr 0x2000, stride 0x40 -> 512 beats all 0xFF00FF00; ram_rd never asserted; bursts at 0x2000 + 0x40*r.
- Wrap and ignored start: addr 0xFFFFFC00, stride 0x400 -> row 1 at 0x00000000. A second start pulse while busy changes nothing.
- Reset mid-operation: rst asserted during burst 5 beat 7 -> next cycle master_write = 0, busy = 0. A new start then writes a full correct tile from row 0.
- Parameter sweep: TILE_W = 8, TILE_H = 8, RAM_LAT = 1, FIFO_DEPTH = 8 -> 8 bursts of 8, burstcount = 8, data in order, done asserted.
